// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared state encoding and default widths
// Imported by the interface, the adder and the top.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 20;
  localparam int COUNT_DEF  = 8;
  // Wide enough for COUNT up to 255.
  localparam int CNT_W      = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input and frame-total output handshakes
// master drives products and consumes totals; slave is the accumulator.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;

  modport master (
    output in_valid, prod_in, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, prod_in, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// rtl/product_accumulator_acc_adder.sv - ACC_W+1-bit accumulate adder with carry-out
// SATURATE_EN: clamp to all-ones on carry or once the frame has already overflowed.
module acc_adder
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  input  logic              sat_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  assign full    = {1'b0, a_i} + (ACC_W + 1)'(b_i);
  assign carry_o = full[ACC_W];

`ifdef SATURATE_EN
  assign sum_o = (carry_o || sat_i) ? '1 : full[ACC_W-1:0];
`else
  logic unused_sat;
  assign unused_sat = sat_i;
  assign sum_o      = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT products per frame and holds the total until taken
// Result wraps by default; SATURATE_EN selects clamping (see acc_adder).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int COUNT  = COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  product_accumulator_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic [ACC_W-1:0] add_a, sum;
  logic             add_sat, carry, accept;

  assign accept  = bus.in_valid && in_ready_q;
  // The first product of a frame is added to zero so IDLE and ACCUM share one adder.
  assign add_a   = (state_q == IDLE) ? '0 : acc_q;
  assign add_sat = (state_q == IDLE) ? 1'b0 : ovf_q;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_adder (
    .a_i     (add_a),
    .b_i     (bus.prod_in),
    .sat_i   (add_sat),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = sum;
            ovf_d   = carry;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // in_ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      in_ready_q <= (state_d != DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;

endmodule
